// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: bus widths, FSM state encodings and port IDs.
package mem_arbiter_pkg;

    localparam int ADDRSIZE = 32;
    localparam int WORDSIZE = 32;

    typedef enum logic [1:0] {
        MEM_ARB_STATE_IDLE = 2'd0,
        MEM_ARB_STATE_REQ  = 2'd1,
        MEM_ARB_STATE_WAIT = 2'd2,
        MEM_ARB_STATE_RESP = 2'd3
    } memArbState_e;

    typedef enum logic {
        MEM_ARB_PORT_IF = 1'b0,
        MEM_ARB_PORT_LS = 1'b1
    } memArbPort_e;

endpackage

// File: rtl/mem_arbiter_pick.sv
// Grant selection between fetch and load/store requests; one-hot grant {ls, if}.
// MEM_ARB_RR_EN selects round-robin on contention, otherwise ls always wins.
module mem_arb_pick (
    input  logic       ifReq_i,
    input  logic       lsReq_i,
    input  logic       lastGrant_i,
    output logic [1:0] grant_o
);

`ifdef MEM_ARB_RR_EN
    // lastGrant_i = 1 means ls won the previous contention, so if goes next
    always_comb begin
        grant_o = 2'b00;
        if (ifReq_i && lsReq_i) begin
            grant_o = lastGrant_i ? 2'b01 : 2'b10;
        end else if (lsReq_i) begin
            grant_o = 2'b10;
        end else if (ifReq_i) begin
            grant_o = 2'b01;
        end
    end
`else
    logic unusedLastGrant;
    assign unusedLastGrant = lastGrant_i;

    always_comb begin
        grant_o = 2'b00;
        if (lsReq_i) begin
            grant_o = 2'b10;
        end else if (ifReq_i) begin
            grant_o = 2'b01;
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch, load/store) arbiter in front of a single memory controller.
// Optional round-robin contention handling via MEM_ARB_RR_EN.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ACK_TIMEOUT = 15
) (
    input  logic                ma_clk_i,
    input  logic                ma_rst_i,
    input  logic                ma_if_req_i,
    input  logic [ADDRSIZE-1:0] ma_if_addr_i,
    output logic [WORDSIZE-1:0] ma_if_data_o,
    output logic                ma_if_ack_o,
    input  logic                ma_ls_req_i,
    input  logic                ma_ls_we_i,
    input  logic [ADDRSIZE-1:0] ma_ls_addr_i,
    input  logic [WORDSIZE-1:0] ma_ls_data_i,
    output logic [WORDSIZE-1:0] ma_ls_data_o,
    output logic                ma_ls_ack_o,
    output logic                ma_hello_o,
    output logic                ma_we_o,
    output logic [ADDRSIZE-1:0] ma_addr_o,
    output logic [WORDSIZE-1:0] ma_data_o,
    input  logic [WORDSIZE-1:0] ma_data_i,
    input  logic                ma_ack_i,
    output logic                ma_err_o,
    output logic                ma_busy_o
);

    localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    memArbState_e        state_q, state_d;
    memArbPort_e         port_q, port_d;
    logic                we_q, we_d;
    logic [ADDRSIZE-1:0] addr_q, addr_d;
    logic [WORDSIZE-1:0] wdata_q, wdata_d;
    logic [WORDSIZE-1:0] ifData_q, ifData_d;
    logic [WORDSIZE-1:0] lsData_q, lsData_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                err_q, err_d;
    logic                lastGrant_q, lastGrant_d;
    logic [1:0]          grant;
    logic                timeoutHit;
    logic                driveBus;
    logic [WORDSIZE-1:0] respData;

    mem_arb_pick uPick (
        .ifReq_i     (ma_if_req_i),
        .lsReq_i     (ma_ls_req_i),
        .lastGrant_i (lastGrant_q),
        .grant_o     (grant)
    );

    assign timeoutHit = (ACK_TIMEOUT != 0) && (cnt_q == CNT_W'(ACK_TIMEOUT - 1));
    assign respData   = (ma_ack_i && !we_q) ? ma_data_i : '0;

    always_comb begin
        state_d     = state_q;
        port_d      = port_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        ifData_d    = ifData_q;
        lsData_d    = lsData_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        lastGrant_d = lastGrant_q;
        case (state_q)
            MEM_ARB_STATE_IDLE: begin
                if (grant != 2'b00) begin
                    state_d = MEM_ARB_STATE_REQ;
                    err_d   = 1'b0;
                    // Pointer only moves on real contention so a lone request never steals a turn
                    if (ma_if_req_i && ma_ls_req_i) begin
                        lastGrant_d = grant[1];
                    end
                    if (grant[1]) begin
                        port_d  = MEM_ARB_PORT_LS;
                        we_d    = ma_ls_we_i;
                        addr_d  = ma_ls_addr_i;
                        wdata_d = ma_ls_data_i;
                    end else begin
                        port_d  = MEM_ARB_PORT_IF;
                        we_d    = 1'b0;
                        addr_d  = ma_if_addr_i;
                        wdata_d = '0;
                    end
                end
            end
            MEM_ARB_STATE_REQ: begin
                state_d = MEM_ARB_STATE_WAIT;
                cnt_d   = '0;
            end
            MEM_ARB_STATE_WAIT: begin
                if (ma_ack_i || timeoutHit) begin
                    state_d = MEM_ARB_STATE_RESP;
                    err_d   = !ma_ack_i;
                    if (port_q == MEM_ARB_PORT_LS) begin
                        lsData_d = respData;
                    end else begin
                        ifData_d = respData;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            MEM_ARB_STATE_RESP: begin
                state_d = MEM_ARB_STATE_IDLE;
            end
            default: begin
                state_d = MEM_ARB_STATE_IDLE;
            end
        endcase
    end

    always_ff @(posedge ma_clk_i or posedge ma_rst_i) begin
        if (ma_rst_i) begin
            state_q     <= MEM_ARB_STATE_IDLE;
            port_q      <= MEM_ARB_PORT_IF;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            ifData_q    <= '0;
            lsData_q    <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            lastGrant_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            port_q      <= port_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            ifData_q    <= ifData_d;
            lsData_q    <= lsData_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            lastGrant_q <= lastGrant_d;
        end
    end

    assign driveBus     = (state_q == MEM_ARB_STATE_REQ) || (state_q == MEM_ARB_STATE_WAIT);
    assign ma_hello_o   = (state_q == MEM_ARB_STATE_REQ);
    assign ma_busy_o    = (state_q != MEM_ARB_STATE_IDLE);
    assign ma_we_o      = driveBus & we_q;
    assign ma_addr_o    = driveBus ? addr_q : '0;
    assign ma_data_o    = driveBus ? wdata_q : '0;
    assign ma_if_ack_o  = (state_q == MEM_ARB_STATE_RESP) && (port_q == MEM_ARB_PORT_IF);
    assign ma_ls_ack_o  = (state_q == MEM_ARB_STATE_RESP) && (port_q == MEM_ARB_PORT_LS);
    assign ma_err_o     = (state_q == MEM_ARB_STATE_RESP) && err_q;
    assign ma_if_data_o = ifData_q;
    assign ma_ls_data_o = lsData_q;

endmodule
